// File: rtl/alu_seq.sv
// alu_seq: registered, width-parametrised ALU.
//   Single-cycle operations register their result one clock after accept.
//   Signed mul/div run on an iterative engine, one step per clock for WIDTH
//   clocks, behind a Start/Busy/Done handshake.
// Ports:
//   Clock   - rising-edge clock
//   Clear   - asynchronous active-high reset
//   Start   - request strobe, accepted only while Busy=0
//   Control - 5-bit opcode
//   reg_A   - operand A
//   reg_B   - operand B / shift amount (low SHW bits)
//   Busy    - mul/div engine iterating
//   Done    - one-cycle pulse when reg_C updates
//   reg_C   - 2*WIDTH result; {HI, LO}. Non-mul/div results are zero-extended.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Start,
    input  logic [4:0]           Control,
    input  logic [WIDTH-1:0]     reg_A,
    input  logic [WIDTH-1:0]     reg_B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   reg_C
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHLA = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_ADDI = 5'b10010;
    localparam logic [4:0] OP_ANDI = 5'b10011;
    localparam logic [4:0] OP_ORI  = 5'b10100;

    typedef enum logic {IDLE, RUN} state_t;

    // Magnitude of a signed operand; most-negative maps to 2^(WIDTH-1),
    // which still fits the unsigned WIDTH-bit result.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] alu_single(input logic [4:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHW-1:0]     sh;
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   r;
        sh  = b[SHW-1:0];
        dbl = '0;
        r   = '0;
        case (op)
            OP_ADD, OP_ADDI: r = a + b;
            OP_SUB:          r = a - b;
            OP_SHL, OP_SHLA: r = a << sh;
            OP_SHR:          r = a >> sh;
            OP_SHRA:         r = $signed(a) >>> sh;
            // Rotates: shift a doubled copy and keep the wrapped window.
            OP_ROL: begin
                dbl = {a, a} << sh;
                r   = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = {a, a} >> sh;
                r   = dbl[WIDTH-1:0];
            end
            OP_AND, OP_ANDI: r = a & b;
            OP_OR, OP_ORI:   r = a | b;
            OP_NOT:          r = ~b;
            OP_NEG:          r = -b;
            default:         r = '0;
        endcase
        return r;
    endfunction

    state_t             state, state_nxt;
    logic [SHW-1:0]     cnt, cnt_nxt;
    logic               done_nxt;
    logic               load_c;
    logic [2*WIDTH-1:0] c_nxt;
    logic               accept;
    logic               is_md;

    // Engine registers (data only, no reset)
    logic               is_div_p0;
    logic               q_neg_p0;
    logic               a_neg_p0;
    logic               b_zero_p0;
    logic [WIDTH-1:0]   a_raw_p0;
    logic [WIDTH-1:0]   dvs_p0;
    logic [2*WIDTH-1:0] prod_p0;
    logic [WIDTH-1:0]   rem_p0;
    logic [WIDTH-1:0]   quo_p0;

    logic [WIDTH:0]     hi_sum;
    logic [WIDTH:0]     r_sh;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic [2*WIDTH-1:0] md_res;

    assign Busy   = (state == RUN);
    assign accept = Start && (state == IDLE);
    assign is_md  = (Control == OP_MUL) || (Control == OP_DIV);

    // Stage p0 -> step: one shift-add (mul) and one restoring step (div)
    always_comb begin
        hi_sum    = {1'b0, prod_p0[2*WIDTH-1:WIDTH]} + (prod_p0[0] ? {1'b0, dvs_p0} : '0);
        prod_step = {hi_sum, prod_p0[WIDTH-1:1]};
        r_sh      = {rem_p0, quo_p0[WIDTH-1]};
        if (r_sh >= {1'b0, dvs_p0}) begin
            rem_step = r_sh[WIDTH-1:0] - dvs_p0;
            quo_step = {quo_p0[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = r_sh[WIDTH-1:0];
            quo_step = {quo_p0[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up on the final step; divide-by-zero is overridden outright.
    always_comb begin
        q_fin = q_neg_p0 ? -quo_step : quo_step;
        r_fin = a_neg_p0 ? -rem_step : rem_step;
        if (is_div_p0) begin
            md_res = b_zero_p0 ? {a_raw_p0, {WIDTH{1'b1}}} : {r_fin, q_fin};
        end else begin
            md_res = q_neg_p0 ? -prod_step : prod_step;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        load_c    = 1'b0;
        c_nxt     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_md) begin
                        state_nxt = RUN;
                        cnt_nxt   = SHW'(WIDTH - 1);
                    end else begin
                        load_c   = 1'b1;
                        c_nxt    = {{WIDTH{1'b0}}, alu_single(Control, reg_A, reg_B)};
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    load_c    = 1'b1;
                    c_nxt     = md_res;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= IDLE;
            cnt   <= '0;
            Done  <= 1'b0;
            reg_C <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Done  <= done_nxt;
            if (load_c) begin
                reg_C <= c_nxt;
            end
        end
    end

    // Input -> p0: capture operand magnitudes and signs at accept
    always_ff @(posedge Clock) begin
        if (accept && is_md) begin
            is_div_p0 <= (Control == OP_DIV);
            q_neg_p0  <= reg_A[WIDTH-1] ^ reg_B[WIDTH-1];
            a_neg_p0  <= reg_A[WIDTH-1];
            b_zero_p0 <= (reg_B == '0);
            a_raw_p0  <= reg_A;
            dvs_p0    <= mag(reg_B);
            prod_p0   <= {{WIDTH{1'b0}}, mag(reg_A)};
            rem_p0    <= '0;
            quo_p0    <= mag(reg_A);
        end else if (state == RUN) begin
            prod_p0 <= prod_step;
            rem_p0  <= rem_step;
            quo_p0  <= quo_step;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, width-parametrised ALU for the datapath.
- Single-cycle operations return one clock after Start.
- Signed multiply and divide run on an iterative WIDTH-cycle engine behind a Start/Busy/Done handshake.
- reg_C is 2*WIDTH wide and feeds the HI/LO and Z registers: upper half is HI, lower half is LO.

Parameters:
- WIDTH, 32: operand width. Power of two, 4 or more.
- SHW, $clog2(WIDTH): localparam, number of shift-amount bits taken from reg_B.

Ports:
- Clock  in  1: rising-edge clock.
- Clear  in  1: asynchronous, active-high reset.
- Start  in  1: request strobe, sampled only when Busy=0.
- Control  in  5: opcode, encoding below.
- reg_A  in  WIDTH: operand A, captured at accept.
- reg_B  in  WIDTH: operand B or shift amount, captured at accept.
- Busy  out  1: high while the multiply/divide engine is iterating.
- Done  out  1: one-cycle pulse when reg_C updates.
- reg_C  out  2*WIDTH: registered result.

Behaviour:
Reset (Clear=1, any time, including mid-operation):
- State goes to IDLE; counter = 0.
- Busy=0, Done=0, reg_C=0.
- Any partial product or partial quotient is discarded; no Done is produced for an aborted operation.

Opcodes:
- 00000 add, 10010 addi: A+B, wraps mod 2^WIDTH.
- 00001 sub: A−B, wraps.
- 00010 mul: signed product.
- 00011 div: signed divide.
- 00100 shl, 00111 shla: A << B[SHW-1:0].
- 00101 shr: logical right shift.
- 01000 shra: arithmetic right shift.
- 01001 rol, 01010 ror: rotate by B[SHW-1:0].
- 01011 and, 10011 andi: A & B.
- 01100 or, 10100 ori: A | B.
- 01101 not: ~B.
- 01110 neg: −B.
- Any other opcode: result 0, still completes single-cycle with Done.
- Non-mul/div results: zero-extended into reg_C, upper WIDTH bits = 0.

Accept: Start=1 while Busy=0 at edge t.
- Control, reg_A and reg_B are latched; later input changes are ignored.
- Start while Busy=1 is ignored: no queueing, no error.

Single-cycle path (IDLE→IDLE):
- reg_C is updated and Done=1 in the cycle after edge t.

Multi-cycle path, states IDLE→RUN→IDLE:
- Busy=1 for exactly WIDTH cycles after edge t.
- Counter counts WIDTH-1 down to 0.
- On the edge where the counter reaches 0: reg_C is written, Done=1 for one cycle, Busy=0.
- Latency from Start to Done is WIDTH+1 cycles.
- mul: one shift-add step per cycle on operand magnitudes, sign applied at the end. reg_C is the full 2*WIDTH signed product.
- div: restoring division, one quotient bit per cycle on magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend. reg_C = {remainder, quotient}.
- div by zero: quotient = all ones, remainder = A. Still takes full latency.
- div of most-negative by −1: quotient = most-negative, remainder = 0.

Hold and back-to-back:
- reg_C holds its value between Done pulses.
- Done never coincides with Busy=1.
- Start is accepted in the same cycle Done is high, so operations can issue back-to-back.

Test Plan:
1. WIDTH=32, add A=32'hFFFFFFFF, B=1 → one cycle later Done=1, reg_C=64'h0; then ror A=1, B=1 → reg_C=64'h0000_0000_8000_0000.
2. mul A=−3, B=7 → Busy high 32 cycles, Done at t+33, reg_C=64'hFFFF_FFFF_FFFF_FFEB. Start pulses with add during Busy are ignored and reg_C is unchanged until Done.
3. div A=−7, B=2 → reg_C=64'hFFFF_FFFF_FFFF_FFFD (remainder −1, quotient −3). div A=10, B=0 → reg_C=64'h0000_000A_FFFF_FFFF.
4. shra A=32'h8000_0000, B=32'h0000_0024 → shift amount 4, reg_C=64'h0000_0000_F800_0000. shla with the same inputs → reg_C=64'h0.
5. Start mul, assert Clear asynchronously mid-cycle at iteration 10 → Busy, Done and reg_C go to 0 immediately, with no Done afterwards. Next add 2+3 → reg_C=5 one cycle later.
6. Back-to-back: div completes, Start of sub 5−9 in the Done cycle → reg_C=64'h0000_0000_FFFF_FFFC one cycle later. Repeat tests 2 and 3 with WIDTH=8: mul −3×7 → reg_C=16'hFFEB, Done at t+9.
